hrb_inject_arbiter: RTL
=======================

Name: hrb_inject_arbiter

Overview:
- Schedules injection from the bridge transfer FIFOs into one outgoing ring slot of the hierarchical-ring bridge.
- Up to NREQ FIFOs (e.g. the four global-side FIFOs feeding local port l0) compete for the slot.
- Grants only when the ring slot is free and downstream is not full, using round-robin priority.
- Raises a starvation throttle toward the ring when pending traffic is blocked for too long.

Parameters:
- NREQ, 4, number of requesting FIFOs (2..8).
- SEL_W, 2, width of sel_o; equals clog2(NREQ).
- STARVE_TH, 8, consecutive blocked cycles before starvation is declared (1..255).
- CNT_W, 8, width of the wait counter; must hold STARVE_TH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  NREQ  bit i high = FIFO i non-empty.
- slot_busy_i  in  1  incoming ring flit occupies the output slot this cycle.
- bfull_i  in  1  downstream buffer full.
- grant_o  out  NREQ  one-hot grant, combinational this cycle.
- deQ_o  out  NREQ  dequeue strobe to FIFO i; equals grant_o.
- sel_o  out  SEL_W  binary index of the granted FIFO (datapath mux select); 0 when no grant.
- enQ_o  out  1  inject strobe; OR of grant_o.
- starve_o  out  1  registered request for the ring to free a slot.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. State is updated only on the rising edge.
- Reset values: prio_ptr=0, wait_cnt=0, state=NORMAL, starve_o=0. While rst=1, grant_o, deQ_o, enQ_o and sel_o are forced to 0.
- Grant eligibility: can_go = |req_i & !slot_busy_i & !bfull_i. If can_go is 0, grant_o is 0.
- Round-robin: search starts at prio_ptr and wraps modulo NREQ. The first set req bit wins.
- After a grant to index k, prio_ptr <= (k+1) mod NREQ. Without a grant, prio_ptr holds.
- Latency: zero cycles. A grant appears in the same cycle as eligibility. FIFO data is consumed at the next rising edge.
- wait_cnt:
  - Cleared on any grant, and when req_i is all zeros.
  - Otherwise increments while |req_i & !can_go.
  - Saturates at STARVE_TH.
- FSM states: NORMAL, STARVE.
  - NORMAL -> STARVE when wait_cnt==STARVE_TH-1 and the current cycle is blocked. starve_o rises the next cycle.
  - STARVE: starve_o=1. Grant rules are unchanged.
  - STARVE -> NORMAL on any grant, or when req_i goes to zero. starve_o falls the following cycle and wait_cnt clears.
- Simultaneous slot_busy_i and bfull_i: no grant; counts as blocked.
- Requests dropping mid-wait: the counter clears and there is no residual starvation.
- Only slot_busy_i blocked (bfull_i=0): still counts as blocked.
- Reset mid-STARVE: next cycle NORMAL, starve_o=0, prio_ptr=0.
- No combinational path from req_i to starve_o.

Decomposition:
- Shared package holds:
  - the state encoding (NORMAL=1'b0, STARVE=1'b1);
  - `control_w width constant (144);
  - default NREQ and STARVE_TH.
- One sub-module, rr_pick: a combinational round-robin picker taking req, ptr and en, returning one-hot grant, index and valid. It is reused by sibling bridge schedulers.

Test Plan:
- Reset: rst=1 with req_i=4'b1111 -> grant_o=0, enQ_o=0, starve_o=0. First free cycle after reset grants FIFO0 (sel_o=0).
- Rotation: req_i=4'b1111, slot free, bfull=0 for 4 cycles -> grants 0001, 0010, 0100, 1000 in order; prio_ptr wraps to 0.
- Sparse wrap: prio_ptr=3, req_i=4'b0101 -> grant 0001 (sel_o=0); next cycle grant 0100.
- Blocked: bfull_i=1 with any req -> grant_o=0, deQ_o=0. Outputs release in the same cycle bfull_i drops.
- Starvation: STARVE_TH=8, req_i=4'b0010, slot_busy_i=1 for 10 cycles -> starve_o rises on cycle 9 after the first blocked edge and stays high. Then slot_busy_i=0 -> grant 0010; starve_o=0 next cycle; wait_cnt=0.
- Mid-starve reset: assert rst during STARVE -> starve_o=0 and state NORMAL after one edge.

Source files
------------

// File: rtl/hrb_inject_arbiter_pkg.sv
// Shared definitions for the hierarchical-ring bridge injection schedulers.
package hrb_inject_arbiter_pkg;

  // Starvation FSM encoding
  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_STARVE = 1'b1
  } state_e;

  // Width of the bridge control word carried alongside injected flits
  localparam int CONTROL_W = 144;

  // Default number of competing transfer FIFOs
  localparam int DEFAULT_NREQ = 4;

  // Default number of consecutive blocked cycles before starvation
  localparam int DEFAULT_STARVE_TH = 8;

endpackage : hrb_inject_arbiter_pkg

// File: rtl/hrb_inject_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts at ptr, wraps modulo N,
// and the first set request bit wins. Shared by the bridge schedulers.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0]     grant_s;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Walk the requests from ptr upward with wrap, keep the first hit
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int o = 0; o < N; o++) begin
      cand_s = IDX_W'((int'(ptr) + o) % N);
      if (en && !found_s && req[cand_s]) begin
        found_s         = 1'b1;
        grant_s[cand_s] = 1'b1;
        idx_s           = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant = grant_s;
  assign idx   = idx_s;
  assign valid = found_s;

endmodule : rr_pick

// File: rtl/hrb_inject_arbiter.sv
// Injection arbiter: schedules one of NREQ bridge transfer FIFOs into the
// outgoing ring slot and requests a free slot when traffic starves.
module hrb_inject_arbiter
  import hrb_inject_arbiter_pkg::*;
#(
  parameter int NREQ      = DEFAULT_NREQ,
  parameter int SEL_W     = 2,
  parameter int STARVE_TH = DEFAULT_STARVE_TH,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_i,
  input  logic             slot_busy_i,
  input  logic             bfull_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [NREQ-1:0]  deQ_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             enQ_o,
  output logic             starve_o
);

  localparam logic [CNT_W-1:0] TH_C       = CNT_W'(STARVE_TH);
  localparam logic [CNT_W-1:0] TH_M1_C    = CNT_W'(STARVE_TH - 1);
  localparam logic [SEL_W-1:0] LAST_IDX_C = SEL_W'(NREQ - 1);

  logic             any_req_s;
  logic             can_go_s;
  logic             blocked_s;
  logic             pick_en_s;
  logic             pick_valid_s;
  logic [NREQ-1:0]  pick_grant_s;
  logic [SEL_W-1:0] pick_idx_s;

  logic [SEL_W-1:0] prio_ptr_r;
  logic [SEL_W-1:0] prio_ptr_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_s;
  state_e           state_r;
  state_e           state_s;

  // A slot is injectable only if something is pending, the ring slot is free
  // and downstream has room; pending-but-not-injectable counts as blocked.
  assign any_req_s = |req_i;
  assign can_go_s  = any_req_s & ~slot_busy_i & ~bfull_i;
  assign blocked_s = any_req_s & ~can_go_s;
  // Reset masks the grant path so no FIFO is dequeued while held in reset
  assign pick_en_s = can_go_s & ~rst;

  rr_pick #(
    .N     (NREQ),
    .IDX_W (SEL_W)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (prio_ptr_r),
    .en    (pick_en_s),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Grant is zero-latency; dequeue and inject strobes follow it directly
  assign grant_o  = pick_grant_s;
  assign deQ_o    = pick_grant_s;
  assign sel_o    = pick_idx_s;
  assign enQ_o    = pick_valid_s;
  // Starve flag comes straight from the state register: no path from req_i
  assign starve_o = (state_r == ST_STARVE);

  // Next-state logic for priority pointer, wait counter and starvation FSM
  always_comb begin
    prio_ptr_s = prio_ptr_r;
    wait_cnt_s = wait_cnt_r;
    state_s    = state_r;

    if (pick_valid_s) begin
      if (pick_idx_s == LAST_IDX_C) begin
        prio_ptr_s = '0;
      end else begin
        prio_ptr_s = pick_idx_s + SEL_W'(1);
      end
    end else begin
      prio_ptr_s = prio_ptr_r;
    end

    if (pick_valid_s || !any_req_s) begin
      wait_cnt_s = '0;
    end else if (blocked_s && (wait_cnt_r != TH_C)) begin
      wait_cnt_s = wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_s = wait_cnt_r;
    end

    case (state_r)
      ST_NORMAL: begin
        if (blocked_s && (wait_cnt_r == TH_M1_C)) begin
          state_s = ST_STARVE;
        end else begin
          state_s = ST_NORMAL;
        end
      end
      ST_STARVE: begin
        if (pick_valid_s || !any_req_s) begin
          state_s = ST_NORMAL;
        end else begin
          state_s = ST_STARVE;
        end
      end
      default: begin
        state_s = ST_NORMAL;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_r <= '0;
      wait_cnt_r <= '0;
      state_r    <= ST_NORMAL;
    end else begin
      prio_ptr_r <= prio_ptr_s;
      wait_cnt_r <= wait_cnt_s;
      state_r    <= state_s;
    end
  end

endmodule : hrb_inject_arbiter
